// File: rtl/mcp_xfer_buf.sv
// -----------------------------------------------------------------------------
// mcp_xfer_buf
//
// Multi-cycle-path clock-domain-crossing transfer with a source-side buffer.
// Words written on the aclk side are queued in a DEPTH-entry FIFO. The head
// word is copied into a holding register (r_hold) and announced to the bclk
// side by toggling a request bit. Only the request and acknowledge toggles
// are synchronised. The data bus crosses raw. It is safe to sample because
// r_hold is stable from launch until the acknowledge returns.
//
// Parameters
//   DW    : data width (>= 1)
//   DEPTH : source buffer entries (power of 2, >= 1)
//   SYNC  : synchroniser flops per crossing (>= 2)
//
// Ports (source domain, aclk / arst_n)
//   aclk, arst_n : source clock, async active-low reset
//   adatain      : source data
//   asend        : write request
//   aready       : buffer can accept a word this cycle
//   acount       : words held, including the one in flight
//   aovf         : sticky, asend seen while aready was low
//
// Ports (destination domain, bclk / brst_n)
//   bclk, brst_n : destination clock, async active-low reset
//   bdata        : received word, held until replaced
//   bvalid       : bdata holds a word not yet consumed
//   bload        : consume bdata
// -----------------------------------------------------------------------------
module mcp_xfer_buf #(
  parameter int DW    = 8,
  parameter int DEPTH = 2,
  parameter int SYNC  = 2
) (
  input  logic                       aclk,
  input  logic                       arst_n,
  input  logic                       bclk,
  input  logic                       brst_n,
  input  logic [DW-1:0]              adatain,
  input  logic                       asend,
  output logic                       aready,
  output logic [$clog2(DEPTH+1)-1:0] acount,
  output logic                       aovf,
  output logic [DW-1:0]              bdata,
  output logic                       bvalid,
  input  logic                       bload
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Source-domain state.
  logic [DW-1:0]   r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_ovf;
  logic            r_req;
  logic [DW-1:0]   r_hold;
  logic [SYNC-1:0] r_ack_sync;
  state_t          r_state;

  // Destination-domain state.
  logic [SYNC-1:0] r_req_sync;
  logic            r_req_dly;
  logic [DW-1:0]   r_bdata;
  logic            r_bvalid;
  logic            r_back;

  // Source-domain control.
  state_t          w_state_nxt;
  logic            w_write;
  logic            w_pop;
  logic            w_launch;
  logic [AW-1:0]   w_launch_ptr;
  logic            w_ack_seen;
  logic            w_full;

  // Destination-domain control.
  logic            w_pulse;
  logic            w_consume;

  // Pointer advance with wrap at DEPTH. A single-entry buffer always
  // addresses slot 0.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    if (DEPTH == 1) return '0;
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // Source side: FIFO bookkeeping
  // ---------------------------------------------------------------------------
  // aready is derived from registered occupancy only. A pop on the same edge
  // therefore never lets a simultaneous write into a full buffer.
  assign w_full     = (r_count == CW'(DEPTH));
  assign w_write    = asend && !w_full;
  assign w_ack_seen = r_ack_sync[SYNC-1];

  // NOTE: storage is not reset. Slots are only read after being written, and
  // leaving them out of the reset net lets the array map onto plain RAM cells.
  always_ff @(posedge aclk) begin
    if (w_write) r_mem[r_wr_ptr] <= adatain;
  end

  // NOTE: all sequential state uses non-blocking assignments so every flop
  // samples values from before the edge, whatever order the blocks run in.
  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_write) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)   r_rd_ptr <= ptr_inc(r_rd_ptr);
      // A write and a pop on the same edge cancel out.
      r_count <= r_count + CW'(w_write) - CW'(w_pop);
      if (asend && w_full) r_ovf <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Source side: launch / completion FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // NOTE: every signal driven here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt  = r_state;
    w_pop        = 1'b0;
    w_launch     = 1'b0;
    w_launch_ptr = r_rd_ptr;
    unique case (r_state)
      ST_IDLE: begin
        if (r_count != '0) begin
          w_launch    = 1'b1;
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // The acknowledge matches the request once the destination has
        // consumed the word currently held in r_hold.
        if (w_ack_seen == r_req) begin
          w_pop = 1'b1;
          if (r_count > CW'(1)) begin
            // Chain straight into the next entry behind the popped head.
            w_launch     = 1'b1;
            w_launch_ptr = ptr_inc(r_rd_ptr);
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // r_hold changes only at launch, and launch only happens once the previous
  // acknowledge is back. That keeps it stable while bclk may sample it.
  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      r_hold <= '0;
      r_req  <= 1'b0;
    end else if (w_launch) begin
      r_hold <= r_mem[w_launch_ptr];
      r_req  <= ~r_req;
    end
  end

  // Acknowledge toggle brought back into aclk.
  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) r_ack_sync <= '0;
    else         r_ack_sync <= {r_ack_sync[SYNC-2:0], r_back};
  end

  assign aready = !w_full;
  assign acount = r_count;
  assign aovf   = r_ovf;

  // ---------------------------------------------------------------------------
  // Destination side
  // ---------------------------------------------------------------------------
  // Request toggle brought into bclk. The extra delayed copy turns each
  // toggle into a single-cycle pulse.
  always_ff @(posedge bclk or negedge brst_n) begin
    if (!brst_n) begin
      r_req_sync <= '0;
      r_req_dly  <= 1'b0;
    end else begin
      r_req_sync <= {r_req_sync[SYNC-2:0], r_req};
      r_req_dly  <= r_req_sync[SYNC-1];
    end
  end

  assign w_pulse   = r_req_sync[SYNC-1] ^ r_req_dly;
  assign w_consume = r_bvalid && bload;

  // A new pulse cannot coincide with a consume. The next request only
  // leaves the source after this side's acknowledge has been seen there.
  always_ff @(posedge bclk or negedge brst_n) begin
    if (!brst_n) begin
      r_bdata  <= '0;
      r_bvalid <= 1'b0;
      r_back   <= 1'b0;
    end else begin
      if (w_pulse) begin
        r_bdata  <= r_hold;
        r_bvalid <= 1'b1;
      end else if (w_consume) begin
        r_bvalid <= 1'b0;
        r_back   <= ~r_back;
      end
    end
  end

  assign bdata  = r_bdata;
  assign bvalid = r_bvalid;

endmodule

// File: tb/tb_mcp_xfer_buf.sv
// -----------------------------------------------------------------------------
// tb_mcp_xfer_buf
//
// Directed self-checking bench for mcp_xfer_buf at DW=8, DEPTH=2, SYNC=2.
// aclk runs at 10 ns and bclk at 6 ns. Source outputs are sampled on the aclk
// falling edge and destination outputs on the bclk falling edge.
// -----------------------------------------------------------------------------
module tb_mcp_xfer_buf;

  localparam int DW    = 8;
  localparam int DEPTH = 2;
  localparam int SYNC  = 2;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int NSTREAM = 40;

  logic          aclk = 1'b0;
  logic          bclk = 1'b0;
  logic          arst_n;
  logic          brst_n;
  logic [DW-1:0] adatain;
  logic          asend;
  logic          aready;
  logic [CW-1:0] acount;
  logic          aovf;
  logic [DW-1:0] bdata;
  logic          bvalid;
  logic          bload;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 aclk = ~aclk;
  always #3 bclk = ~bclk;

  mcp_xfer_buf #(.DW(DW), .DEPTH(DEPTH), .SYNC(SYNC)) dut (
    .aclk    (aclk),
    .arst_n  (arst_n),
    .bclk    (bclk),
    .brst_n  (brst_n),
    .adatain (adatain),
    .asend   (asend),
    .aready  (aready),
    .acount  (acount),
    .aovf    (aovf),
    .bdata   (bdata),
    .bvalid  (bvalid),
    .bload   (bload)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] stream_word(input int i);
    return DW'(i * 37 + 5);
  endfunction

  task automatic send_word(input logic [DW-1:0] d);
    @(negedge aclk);
    asend   = 1'b1;
    adatain = d;
    @(negedge aclk);
    asend   = 1'b0;
  endtask

  task automatic wait_bvalid(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge bclk);
      if (bvalid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_acount_zero(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge aclk);
      if (acount === '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Waits for a word, returns it and consumes it with a one-cycle bload.
  task automatic take_word(output logic [DW-1:0] d, output bit ok);
    wait_bvalid(60, ok);
    d = bdata;
    if (ok) begin
      bload = 1'b1;
      @(negedge bclk);
      bload = 1'b0;
    end
  endtask

  // Counts bvalid samples over a window in which nothing should arrive.
  task automatic count_bvalid(input int cycles, output int seen);
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge bclk);
      if (bvalid !== 1'b0) seen++;
    end
  endtask

  // Safety net so the run always ends.
  initial begin
    #200us;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit            ok;
    int            seen;
    int            bad;
    logic [DW-1:0] d;
    int            sent;
    int            rcvd;

    arst_n  = 1'b0;
    brst_n  = 1'b0;
    asend   = 1'b0;
    adatain = '0;
    bload   = 1'b0;

    // ---- 1: reset, arst_n released 21 ns before brst_n ----
    #100 arst_n = 1'b1;
    #21  brst_n = 1'b1;
    @(negedge aclk);
    check("rst_aready", aready, 1);
    check("rst_acount", acount, 0);
    check("rst_aovf",   aovf,   0);
    @(negedge bclk);
    check("rst_bvalid", bvalid, 0);
    check("rst_bdata",  bdata,  0);
    repeat (10) @(negedge aclk);
    check("idle_acount", acount, 0);
    check("idle_bvalid", bvalid, 0);

    // ---- 2: single word, held without bload ----
    send_word(8'hA5);
    check("t2_acount", acount, 1);
    check("t2_aready", aready, 1);
    wait_bvalid(30, ok);
    check("t2_arrive", ok, 1);
    check("t2_bdata", bdata, 8'hA5);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge bclk);
      if (bvalid !== 1'b1 || bdata !== 8'hA5) bad++;
    end
    check("t2_hold_bad", bad, 0);
    @(negedge aclk);
    check("t2_acount_held", acount, 1);
    @(negedge bclk);
    bload = 1'b1;
    @(negedge bclk);
    bload = 1'b0;
    check("t2_bvalid_fall", bvalid, 0);
    check("t2_bdata_kept", bdata, 8'hA5);
    wait_acount_zero(SYNC + 4, ok);
    check("t2_pop", ok, 1);

    // ---- 3: fill, overflow, drain ----
    @(negedge aclk);
    asend = 1'b1; adatain = 8'h11;
    @(negedge aclk);
    adatain = 8'h22;
    @(negedge aclk);
    adatain = 8'h33;
    @(negedge aclk);
    asend = 1'b0;
    check("t3_acount_full", acount, 2);
    check("t3_aready_full", aready, 0);
    check("t3_aovf", aovf, 1);
    take_word(d, ok);
    check("t3_w0_ok", ok, 1);
    check("t3_w0", d, 8'h11);
    take_word(d, ok);
    check("t3_w1_ok", ok, 1);
    check("t3_w1", d, 8'h22);
    count_bvalid(60, seen);
    check("t3_no_extra", seen, 0);
    wait_acount_zero(10, ok);
    check("t3_drained", ok, 1);
    check("t3_aovf_sticky", aovf, 1);

    // ---- 6: overlapping reset mid-transfer ----
    @(negedge aclk);
    asend = 1'b1; adatain = 8'h01;
    @(negedge aclk);
    adatain = 8'h02;
    @(negedge aclk);
    asend = 1'b0;
    wait_bvalid(30, ok);
    check("t6_pre_bvalid", ok, 1);
    check("t6_pre_acount", acount, 2);
    arst_n = 1'b0;
    brst_n = 1'b0;
    #1;
    check("t6_aready", aready, 1);
    check("t6_acount", acount, 0);
    check("t6_aovf",   aovf,   0);
    check("t6_bvalid", bvalid, 0);
    check("t6_bdata",  bdata,  0);
    #60;
    @(negedge aclk);
    arst_n = 1'b1;
    #7 brst_n = 1'b1;
    count_bvalid(20, seen);
    check("t6_no_stale", seen, 0);
    check("t6_acount_post", acount, 0);
    send_word(8'h5A);
    take_word(d, ok);
    check("t6_w_ok", ok, 1);
    check("t6_w", d, 8'h5A);
    count_bvalid(60, seen);
    check("t6_once", seen, 0);
    wait_acount_zero(10, ok);
    check("t6_drained", ok, 1);

    // ---- 4: streaming, asend=aready and bload=bvalid ----
    sent = 0;
    rcvd = 0;
    fork
      begin
        for (int c = 0; c < 5000 && sent < NSTREAM; c++) begin
          @(negedge aclk);
          if (aready) begin
            asend   = 1'b1;
            adatain = stream_word(sent);
            sent++;
          end else begin
            asend = 1'b0;
          end
        end
        @(negedge aclk);
        asend = 1'b0;
      end
      begin
        for (int c = 0; c < 8000 && rcvd < NSTREAM; c++) begin
          @(negedge bclk);
          if (bvalid) begin
            check($sformatf("t4_word%0d", rcvd), bdata, stream_word(rcvd));
            rcvd++;
            bload = 1'b1;
          end else begin
            bload = 1'b0;
          end
        end
        @(negedge bclk);
        bload = 1'b0;
      end
    join
    check("t4_sent", sent, NSTREAM);
    check("t4_rcvd", rcvd, NSTREAM);
    count_bvalid(60, seen);
    check("t4_no_dup", seen, 0);
    wait_acount_zero(10, ok);
    check("t4_drained", ok, 1);
    check("t4_aovf", aovf, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
